// File: rtl/bip_debug_tx.sv
// Halt-triggered debug frame sender: snapshots ACC, PC and a run-cycle counter on the rising
// edge of halt, then streams a 7-byte frame to uart_tx over a start/done handshake.
`timescale 1ns/1ps
module bip_debug_tx #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned PC_W   = 11,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_in,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned FIELD_W  = 16;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned LAST_IDX = 6;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FIELD_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic                 halt_q;
  logic [ACC_W-1:0]     acc_sh_q, acc_sh_d;
  logic [PC_W-1:0]      pc_sh_q, pc_sh_d;
  logic [FIELD_W-1:0]   cyc_sh_q, cyc_sh_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 halt_rise;
  logic [FIELD_W-1:0]   pc_ext, acc_ext;
  logic [7:0]           frame_byte;

  assign halt_rise = halt_in & ~halt_q;

  // Run-cycle counter: counts while running, saturates, freezes during halt.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (!halt_in && (cycle_cnt_q != {FIELD_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + FIELD_W'(1);
    end
  end

  // Next-state logic and registered Moore outputs.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_sh_d = acc_sh_q;
    pc_sh_d  = pc_sh_q;
    cyc_sh_d = cyc_sh_q;
    unique case (state_q)
      IDLE: begin
        if (halt_rise) begin
          acc_sh_d = acc_in;
          pc_sh_d  = pc_in;
          cyc_sh_d = cycle_cnt_q;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done_tick) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SEND;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pc_ext  = FIELD_W'(pc_sh_d);
    acc_ext = FIELD_W'(acc_sh_d);
    case (idx_d)
      3'd0:    frame_byte = HEADER;
      3'd1:    frame_byte = pc_ext[15:8];
      3'd2:    frame_byte = pc_ext[7:0];
      3'd3:    frame_byte = acc_ext[15:8];
      3'd4:    frame_byte = acc_ext[7:0];
      3'd5:    frame_byte = cyc_sh_d[15:8];
      3'd6:    frame_byte = cyc_sh_d[7:0];
      default: frame_byte = 8'h00;
    endcase

    tx_start_d   = (state_d == SEND);
    busy_d       = (state_d == SEND) || (state_d == WAIT);
    frame_done_d = (state_d == DONE);
    tx_data_d    = tx_data_q;
    if (state_d == SEND) begin
      tx_data_d = frame_byte;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cycle_cnt_q  <= '0;
      halt_q       <= 1'b0;
      acc_sh_q     <= '0;
      pc_sh_q      <= '0;
      cyc_sh_q     <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cycle_cnt_q  <= cycle_cnt_d;
      halt_q       <= halt_in;
      acc_sh_q     <= acc_sh_d;
      pc_sh_q      <= pc_sh_d;
      cyc_sh_q     <= cyc_sh_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bip_debug_tx.sv
// Bench for bip_debug_tx: randomized halt frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_bip_debug_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_in;
  logic [15:0] acc_in;
  logic [10:0] pc_in;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;

  bip_debug_tx dut (
    .clk(clk), .reset(reset), .halt_in(halt_in), .acc_in(acc_in), .pc_in(pc_in),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: number of running (halt low) clocks since reset; saturation applied when read.
  int low_cycles;
  always @(posedge clk or posedge reset) begin
    if (reset) low_cycles <= 0;
    else if (!halt_in) low_cycles <= low_cycles + 1;
  end

  // Observations gathered by the UART-side responder.
  logic [7:0] got [7];
  int   got_n, lat_bad, stable_bad, timeouts, extra_starts, fd_count;
  logic fd_pulse, fd_after, busy_after;

  logic [10:0] exp_pc;
  logic [15:0] exp_acc;
  int          exp_cyc;

  function automatic logic [7:0] exp_byte(input int i, input logic [10:0] pc,
                                          input logic [15:0] acc, input int cyc);
    logic [15:0] c;
    logic [15:0] p;
    c = (cyc > 65535) ? 16'hFFFF : 16'(cyc);
    p = {5'b0, pc};
    case (i)
      0: return 8'hA5;
      1: return p[15:8];
      2: return p[7:0];
      3: return acc[15:8];
      4: return acc[7:0];
      5: return c[15:8];
      default: return c[7:0];
    endcase
  endfunction

  // Acts as uart_tx: waits for tx_start, holds 16 cycles, returns tx_done_tick.
  task automatic collect(input int nbytes, input bit pulse_send, input bit glitch);
    got_n = 0; lat_bad = 0; stable_bad = 0; timeouts = 0; extra_starts = 0; fd_count = 0;
    fd_pulse = 1'b0; fd_after = 1'b1; busy_after = 1'b1;
    for (int i = 0; i < 7; i++) got[i] = 8'hxx;
    for (int b = 0; b < nbytes; b++) begin
      int  w;
      bit  seen;
      w = 0; seen = 0;
      while (!seen && w < 40) begin
        @(negedge clk);
        tx_done_tick = 1'b0;
        w++;
        if (frame_done) fd_count++;
        if (tx_start) seen = 1;
      end
      if (!seen) begin
        timeouts++;
        break;
      end
      if (w != 1) lat_bad++;
      got[b] = tx_data;
      got_n++;
      if (pulse_send) tx_done_tick = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        tx_done_tick = 1'b0;
        acc_in = 16'($urandom);
        pc_in  = 11'($urandom);
        if (glitch && b == 2 && i == 3) halt_in = 1'b0;
        if (glitch && b == 2 && i == 4) halt_in = 1'b1;
        if (tx_start || !busy || tx_data !== got[b]) stable_bad++;
        if (frame_done) fd_count++;
      end
      if (!(nbytes < 7 && b == nbytes - 1)) tx_done_tick = 1'b1;
    end
    if (nbytes == 7 && timeouts == 0) begin
      @(negedge clk);
      tx_done_tick = 1'b0;
      fd_pulse   = frame_done;
      busy_after = busy;
      @(negedge clk);
      fd_after = frame_done;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (tx_start) extra_starts++;
        if (frame_done) fd_count++;
      end
    end
  endtask

  task automatic trigger(input logic [10:0] pc, input logic [15:0] acc);
    @(negedge clk);
    pc_in = pc; acc_in = acc;
    halt_in = 1'b1;
    exp_pc = pc; exp_acc = acc; exp_cyc = low_cycles;
  endtask

  task automatic test_reset;
    #13;
    reset = 1'b1;
    #1;
    n_total++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b exp 0", tx_start); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h exp 00", tx_data); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b exp 0", frame_done); else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_frame;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b exp 0", busy); else n_pass++;
    trigger(11'h005, 16'h1234);
    collect(7, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
        $display("FAIL basic_byte%0d got %h exp %h", i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
      else n_pass++;
    end
    n_total++;
    if (lat_bad !== 0 || timeouts !== 0 || stable_bad !== 0)
      $display("FAIL basic_handshake lat_bad=%0d timeouts=%0d stable_bad=%0d exp all 0", lat_bad, timeouts, stable_bad);
    else n_pass++;
    n_total++;
    if (fd_pulse !== 1'b1 || fd_after !== 1'b0 || fd_count !== 0)
      $display("FAIL basic_frame_done pulse=%b after=%b extra=%0d exp 1,0,0", fd_pulse, fd_after, fd_count);
    else n_pass++;
    n_total++; if (busy_after !== 1'b0) $display("FAIL basic_busy_after got %b exp 0", busy_after); else n_pass++;
  endtask

  task automatic test_hold_no_retrigger;
    int starts;
    starts = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    n_total++; if (starts !== 0) $display("FAIL hold_retrigger got %0d starts exp 0", starts); else n_pass++;
    halt_in = 1'b0;
    repeat (2) @(negedge clk);
    trigger(11'($urandom), 16'($urandom));
    collect(7, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
        $display("FAIL hold_byte%0d got %h exp %h", i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
      else n_pass++;
    end
    n_total++;
    if (lat_bad !== 0 || timeouts !== 0 || stable_bad !== 0 || fd_pulse !== 1'b1 || extra_starts !== 0)
      $display("FAIL hold_handshake lat=%0d to=%0d stable=%0d fd=%b extra=%0d exp 0,0,0,1,0",
               lat_bad, timeouts, stable_bad, fd_pulse, extra_starts);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    halt_in = 1'b0;
    repeat ($urandom_range(20, 5)) @(negedge clk);
    trigger(11'($urandom), 16'($urandom));
    collect(4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
        $display("FAIL abort_byte%0d got %h exp %h", i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
      else n_pass++;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_total++;
    if (tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || frame_done !== 1'b0)
      $display("FAIL abort_outputs start=%b busy=%b data=%h fd=%b exp 0,0,00,0", tx_start, busy, tx_data, frame_done);
    else n_pass++;
    halt_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat ($urandom_range(30, 3)) @(negedge clk);
    trigger(11'($urandom), 16'($urandom));
    collect(7, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
        $display("FAIL abort_next_byte%0d got %h exp %h", i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
      else n_pass++;
    end
    n_total++;
    if (lat_bad !== 0 || timeouts !== 0 || stable_bad !== 0 || fd_pulse !== 1'b1)
      $display("FAIL abort_next_handshake lat=%0d to=%0d stable=%0d fd=%b exp 0,0,0,1", lat_bad, timeouts, stable_bad, fd_pulse);
    else n_pass++;
  endtask

  task automatic test_ignored_events;
    halt_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); tx_done_tick = 1'b1;
      @(negedge clk); tx_done_tick = 1'b0;
    end
    n_total++; if (busy !== 1'b0 || tx_start !== 1'b0) $display("FAIL idle_tick busy=%b start=%b exp 0,0", busy, tx_start); else n_pass++;
    trigger(11'($urandom), 16'($urandom));
    collect(7, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
        $display("FAIL ignore_byte%0d got %h exp %h", i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
      else n_pass++;
    end
    n_total++;
    if (got_n !== 7 || extra_starts !== 0 || fd_count !== 0 || fd_pulse !== 1'b1)
      $display("FAIL ignore_count bytes=%0d extra=%0d stray_fd=%0d fd=%b exp 7,0,0,1", got_n, extra_starts, fd_count, fd_pulse);
    else n_pass++;
    n_total++;
    if (lat_bad !== 0 || stable_bad !== 0)
      $display("FAIL ignore_handshake lat=%0d stable=%0d exp 0,0", lat_bad, stable_bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    for (int f = 0; f < 3; f++) begin
      halt_in = 1'b0;
      repeat ($urandom_range(50, 1)) @(negedge clk);
      trigger(11'($urandom), 16'($urandom));
      collect(7, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
        n_total++;
        if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
          $display("FAIL b2b%0d_byte%0d got %h exp %h", f, i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
        else n_pass++;
      end
      n_total++;
      if (lat_bad !== 0 || timeouts !== 0 || stable_bad !== 0 || fd_pulse !== 1'b1 || busy_after !== 1'b0)
        $display("FAIL b2b%0d_handshake lat=%0d to=%0d stable=%0d fd=%b busy=%b exp 0,0,0,1,0",
                 f, lat_bad, timeouts, stable_bad, fd_pulse, busy_after);
      else n_pass++;
    end
  endtask

  task automatic test_saturate;
    halt_in = 1'b0;
    repeat (70000) @(negedge clk);
    trigger(11'($urandom), 16'($urandom));
    collect(7, 1'b0, 1'b0);
    n_total++;
    if (got[5] !== 8'hFF || got[6] !== 8'hFF)
      $display("FAIL sat_cyc got %h%h exp FFFF", got[5], got[6]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (got[i] !== exp_byte(i, exp_pc, exp_acc, exp_cyc))
        $display("FAIL sat_byte%0d got %h exp %h", i, got[i], exp_byte(i, exp_pc, exp_acc, exp_cyc));
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0; halt_in = 1'b0; tx_done_tick = 1'b0;
    acc_in = 16'h0000; pc_in = 11'h000;
    test_reset();
    test_basic_frame();
    test_hold_no_retrigger();
    test_reset_mid_frame();
    test_ignored_events();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation exceeded time limit, passed %0d of %0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
